// File: rtl/priority_decoder_seq.sv
// 2-to-4 decoder that queues encoded indices and replays each one as a one-hot word held HOLD cycles, with one zero cycle between words.
// Latency: a push into an idle, empty block appears on o two edges later. Backpressure: in_ready = !full.
// Optional DEC_STATS_EN adds hit_cnt, four saturating 8-bit per-line DRIVE-entry counters.
module priority_decoder_seq #(
    parameter int HOLD  = 4,
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [1:0]  in_code,
    output logic        in_ready,
    output logic [3:0]  o,
    output logic        o_valid,
    output logic        busy
`ifdef DEC_STATS_EN
    ,
    output logic [31:0] hit_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  hold_q, hold_d;
    logic [1:0]  code_q, code_d;
    logic        pop;

    logic [1:0]  mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic        full, empty, full_d, push;

    logic        in_ready_q;
    logic [3:0]  o_q;
    logic        o_valid_q, busy_q;

    // Extra pointer MSB separates full from empty when the index bits match.
    assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign push   = in_valid && !full;

    assign wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    assign full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= in_code;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        code_d  = code_q;
        pop     = 1'b0;
        case (state_q)
            IDLE, GAP: begin
                if (!empty) begin
                    pop     = 1'b1;
                    code_d  = mem_q[rd_ptr_q[AW-1:0]];
                    hold_d  = 8'(HOLD - 1);
                    state_d = DRIVE;
                end else begin
                    state_d = IDLE;
                end
            end
            DRIVE: begin
                if (hold_q == 8'd0) begin
                    state_d = GAP;
                end else begin
                    hold_d = hold_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered off the current state, so o trails state_q by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            hold_q     <= 8'd0;
            code_q     <= 2'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            in_ready_q <= 1'b1;
            o_q        <= 4'b0000;
            o_valid_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            code_q     <= code_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            in_ready_q <= !full_d;
            o_q        <= (state_q == DRIVE) ? (4'b0001 << code_q) : 4'b0000;
            o_valid_q  <= (state_q == DRIVE);
            busy_q     <= (state_q != IDLE) || !empty;
        end
    end

    assign in_ready = in_ready_q;
    assign o        = o_q;
    assign o_valid  = o_valid_q;
    assign busy     = busy_q;

`ifdef DEC_STATS_EN
    logic [7:0] hit_q [4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                hit_q[k] <= 8'd0;
            end
        end else if (pop && (hit_q[code_d] != 8'hFF)) begin
            hit_q[code_d] <= hit_q[code_d] + 8'd1;
        end
    end

    assign hit_cnt = {hit_q[3], hit_q[2], hit_q[1], hit_q[0]};
`endif

endmodule

// File: tb/tb_priority_decoder_seq.sv
// Directed bench for priority_decoder_seq (HOLD=4, DEPTH=4); covers hit_cnt when DEC_STATS_EN is defined.
module tb_priority_decoder_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [1:0] in_code;
    logic       in_ready;
    logic [3:0] o;
    logic       o_valid;
    logic       busy;
`ifdef DEC_STATS_EN
    logic [31:0] hit_cnt;
`endif

    int tests = 0;
    int fails = 0;

    priority_decoder_seq #(.HOLD(4), .DEPTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_code  (in_code),
        .in_ready (in_ready),
        .o        (o),
        .o_valid  (o_valid),
        .busy     (busy)
`ifdef DEC_STATS_EN
        ,
        .hit_cnt  (hit_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [1:0] fc [6];
        logic [1:0] sw [4];
        logic [3:0] e;
        fc = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd3, 2'd1};
        sw = '{2'd0, 2'd1, 2'd2, 2'd3};

        // Reset held with in_valid toggling
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_code  = 2'd0;
        for (int i = 0; i < 4; i++) begin
            in_valid = i[0];
            tick();
            chk("rst_o", 32'(o), 32'h0);
            chk("rst_o_valid", 32'(o_valid), 32'h0);
            chk("rst_in_ready", 32'(in_ready), 32'h1);
            chk("rst_busy", 32'(busy), 32'h0);
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        tick();

        // Sweep 00,01,10,11 on consecutive edges: 20 cycles of output
        for (int n = 0; n < 22; n++) begin
            in_valid = (n < 4);
            in_code  = (n < 4) ? sw[n] : 2'd0;
            tick();
            if (n >= 2) begin
                int i;
                i = n - 2;
                e = ((i % 5) < 4) ? (4'b0001 << sw[i / 5]) : 4'b0000;
                chk("sweep_o", 32'(o), 32'(e));
                chk("sweep_o_valid", 32'(o_valid), 32'((i % 5) < 4));
            end
        end
        tick();
        chk("sweep_busy_done", 32'(busy), 32'h0);

`ifdef DEC_STATS_EN
        chk("stats_after_sweep", hit_cnt, 32'h01010101);
        begin
            int acc;
            int guard;
            logic rdy;
            acc   = 0;
            guard = 0;
            while (acc < 300 && guard < 5000) begin
                in_valid = 1'b1;
                in_code  = 2'd3;
                rdy      = in_ready;
                tick();
                if (rdy) acc++;
                guard++;
            end
            in_valid = 1'b0;
            chk("stats_pushes", 32'(acc), 32'd300);
            tick();
            tick();
            guard = 0;
            while (busy && guard < 3000) begin
                tick();
                guard++;
            end
            chk("stats_drain", 32'(busy), 32'h0);
            chk("stats_saturate", hit_cnt, 32'hFF010101);
        end
`endif

        // Single code 2'b10
        for (int n = 0; n < 8; n++) begin
            in_valid = (n == 0);
            in_code  = 2'd2;
            tick();
            if (n == 1) begin
                chk("single_o_lat", 32'(o), 32'h0);
                chk("single_busy", 32'(busy), 32'h1);
            end
            if (n >= 2 && n <= 5) begin
                chk("single_o", 32'(o), 32'h4);
                chk("single_o_valid", 32'(o_valid), 32'h1);
            end
            if (n == 6) begin
                chk("single_gap_o", 32'(o), 32'h0);
                chk("single_gap_busy", 32'(busy), 32'h1);
            end
            if (n == 7) chk("single_busy_done", 32'(busy), 32'h0);
        end

        // Full: in_valid held high for six codes
        for (int n = 0; n < 33; n++) begin
            in_valid = (n <= 7);
            in_code  = (n < 5) ? fc[n] : fc[5];
            tick();
            if (n == 0) chk("full_ready_e0", 32'(in_ready), 32'h1);
            if (n == 4) chk("full_ready_e4", 32'(in_ready), 32'h0);
            if (n == 5) chk("full_ready_e5", 32'(in_ready), 32'h0);
            if (n == 6) chk("full_ready_gap_pop", 32'(in_ready), 32'h1);
            if (n == 7) chk("full_ready_e7", 32'(in_ready), 32'h0);
            for (int k = 0; k < 6; k++) begin
                if (n == 2 + 5 * k) begin
                    e = 4'b0001 << fc[k];
                    chk("full_order", 32'(o), 32'(e));
                end
                if (n == 6 + 5 * k) chk("full_gap", 32'(o), 32'h0);
            end
            if (n == 32) chk("full_busy_done", 32'(busy), 32'h0);
        end

        // Reset during DRIVE with 3 entries queued
        for (int n = 0; n < 4; n++) begin
            in_valid = 1'b1;
            in_code  = sw[n];
            tick();
        end
        in_valid = 1'b0;
        chk("midrst_pre_o", 32'(o), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_o_async", 32'(o), 32'h0);
        chk("midrst_o_valid", 32'(o_valid), 32'h0);
        chk("midrst_in_ready", 32'(in_ready), 32'h1);
        chk("midrst_busy", 32'(busy), 32'h0);
        #1;
        rst_n = 1'b1;
        for (int n = 0; n < 8; n++) begin
            in_valid = (n == 0);
            in_code  = 2'd1;
            tick();
            if (n == 1) chk("post_rst_lat", 32'(o), 32'h0);
            if (n == 2) chk("post_rst_o", 32'(o), 32'h2);
            if (n == 6) chk("post_rst_gap", 32'(o), 32'h0);
            if (n == 7) chk("post_rst_empty", 32'(busy), 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
